// File: rtl/uart_rx_frame_ctrl.sv
// UART receive framer: hunts for SYNC, collects ADDR/LEN/payload/CHK under an
// inter-byte timeout, and holds each validated frame for a valid/ack consumer.
module uart_rx_frame_ctrl #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 43400,
    localparam int        IDX_W        = $clog2(MAX_LEN)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_data_ready,
    input  logic [7:0]       i_data_byte,
    output logic             o_frame_valid,
    input  logic             i_frame_ack,
    output logic [7:0]       o_frame_addr,
    output logic [7:0]       o_frame_len,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [7:0]       o_rd_data,
    output logic             o_err_chk,
    output logic             o_err_len,
    output logic             o_err_timeout,
    output logic             o_overrun
);

    typedef enum logic [2:0] {
        S_HUNT    = 3'd0,
        S_ADDR    = 3'd1,
        S_LEN     = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CHK     = 3'd4,
        S_HOLD    = 3'd5
    } state_t;

    localparam int             TMO_W     = $clog2(TIMEOUT_CLKS);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);
    localparam int             DEPTH     = 1 << IDX_W;

    state_t             state_q, state_d;
    logic [7:0]         addr_q, addr_d;
    logic [7:0]         len_q, len_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         chk_q, chk_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               valid_q, valid_d;
    logic               err_chk_q, err_chk_d;
    logic               err_len_q, err_len_d;
    logic               err_tmo_q, err_tmo_d;
    logic               ovr_q, ovr_d;
    logic               mem_we_s;
    logic [7:0]         mem_q [DEPTH];

    logic timed_s, expire_s, len_bad_s, last_s, chk_ok_s;

    // The timeout only runs while a frame is being collected; a byte in the expiry cycle wins.
    assign timed_s   = (state_q == S_ADDR) || (state_q == S_LEN) ||
                       (state_q == S_PAYLOAD) || (state_q == S_CHK);
    assign expire_s  = timed_s && !i_data_ready && (tmo_q == TMO_LAST);
    assign len_bad_s = (i_data_byte == 8'd0) || (i_data_byte > MAX_LEN_B);
    assign last_s    = (8'(cnt_q) == (len_q - 8'd1));
    assign chk_ok_s  = (i_data_byte == chk_q);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HUNT: begin
                if (i_data_ready && (i_data_byte == SYNC_BYTE)) state_d = S_ADDR;
                else                                            state_d = S_HUNT;
            end
            S_ADDR: begin
                if (i_data_ready)  state_d = S_LEN;
                else if (expire_s) state_d = S_HUNT;
                else               state_d = S_ADDR;
            end
            S_LEN: begin
                if (i_data_ready)  state_d = len_bad_s ? S_HUNT : S_PAYLOAD;
                else if (expire_s) state_d = S_HUNT;
                else               state_d = S_LEN;
            end
            S_PAYLOAD: begin
                if (i_data_ready)  state_d = last_s ? S_CHK : S_PAYLOAD;
                else if (expire_s) state_d = S_HUNT;
                else               state_d = S_PAYLOAD;
            end
            S_CHK: begin
                if (i_data_ready)  state_d = chk_ok_s ? S_HOLD : S_HUNT;
                else if (expire_s) state_d = S_HUNT;
                else               state_d = S_CHK;
            end
            S_HOLD: begin
                if (i_frame_ack) state_d = S_HUNT;
                else             state_d = S_HOLD;
            end
            default: state_d = S_HUNT;
        endcase
    end

    // Output and datapath next-state logic.
    always_comb begin
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        chk_d     = chk_q;
        mem_we_s  = 1'b0;
        err_chk_d = 1'b0;
        err_len_d = 1'b0;
        ovr_d     = 1'b0;
        err_tmo_d = expire_s;
        valid_d   = (state_d == S_HOLD);
        if (timed_s && !i_data_ready && (tmo_q != TMO_LAST)) tmo_d = tmo_q + TMO_W'(1);
        else                                                  tmo_d = {TMO_W{1'b0}};
        case (state_q)
            S_ADDR: begin
                if (i_data_ready) begin
                    addr_d = i_data_byte;
                    chk_d  = i_data_byte;
                end else begin
                    addr_d = addr_q;
                end
            end
            S_LEN: begin
                if (i_data_ready && len_bad_s) begin
                    err_len_d = 1'b1;
                end else if (i_data_ready) begin
                    len_d = i_data_byte;
                    chk_d = chk_q ^ i_data_byte;
                    cnt_d = {IDX_W{1'b0}};
                end else begin
                    len_d = len_q;
                end
            end
            S_PAYLOAD: begin
                if (i_data_ready) begin
                    mem_we_s = 1'b1;
                    chk_d    = chk_q ^ i_data_byte;
                    cnt_d    = cnt_q + IDX_W'(1);
                end else begin
                    mem_we_s = 1'b0;
                end
            end
            S_CHK: begin
                if (i_data_ready && !chk_ok_s) err_chk_d = 1'b1;
                else                           err_chk_d = 1'b0;
            end
            S_HOLD: begin
                if (i_data_ready) ovr_d = 1'b1;
                else              ovr_d = 1'b0;
            end
            default: begin
                mem_we_s = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_q    <= 8'd0;
            len_q     <= 8'd0;
            cnt_q     <= {IDX_W{1'b0}};
            chk_q     <= 8'd0;
            tmo_q     <= {TMO_W{1'b0}};
            valid_q   <= 1'b0;
            err_chk_q <= 1'b0;
            err_len_q <= 1'b0;
            err_tmo_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            chk_q     <= chk_d;
            tmo_q     <= tmo_d;
            valid_q   <= valid_d;
            err_chk_q <= err_chk_d;
            err_len_q <= err_len_d;
            err_tmo_q <= err_tmo_d;
            ovr_q     <= ovr_d;
        end
    end

    // Payload buffer; contents deliberately survive reset.
    always_ff @(posedge i_clk) begin
        if (mem_we_s) begin
            mem_q[cnt_q] <= i_data_byte;
        end
    end

    assign o_frame_valid = valid_q;
    assign o_frame_addr  = addr_q;
    assign o_frame_len   = len_q;
    assign o_rd_data     = mem_q[i_rd_idx];
    assign o_err_chk     = err_chk_q;
    assign o_err_len     = err_len_q;
    assign o_err_timeout = err_tmo_q;
    assign o_overrun     = ovr_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl: directed scenarios plus random
// frames whose expected outcome follows from how each frame was built.
module tb_uart_rx_frame_ctrl;

    localparam int MAX_LEN = 16;
    localparam int TMO     = 40;
    localparam int IDX_W   = $clog2(MAX_LEN);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             rdy = 1'b0;
    logic [7:0]       din = 8'h00;
    logic             ack = 1'b0;
    logic [IDX_W-1:0] rd_idx = '0;
    logic             o_frame_valid, o_err_chk, o_err_len, o_err_timeout, o_overrun;
    logic [7:0]       o_frame_addr, o_frame_len, o_rd_data;

    int n_cmp = 0;
    int n_bad = 0;
    int c_chk = 0, c_len = 0, c_tmo = 0, c_ovr = 0, c_multi = 0;

    logic [7:0] frm[$];
    logic [7:0] pl[$];

    uart_rx_frame_ctrl #(.SYNC_BYTE(8'hA5), .MAX_LEN(MAX_LEN), .TIMEOUT_CLKS(TMO)) dut (
        .i_clk(clk), .i_rst(rst), .i_data_ready(rdy), .i_data_byte(din),
        .o_frame_valid(o_frame_valid), .i_frame_ack(ack),
        .o_frame_addr(o_frame_addr), .o_frame_len(o_frame_len),
        .i_rd_idx(rd_idx), .o_rd_data(o_rd_data),
        .o_err_chk(o_err_chk), .o_err_len(o_err_len),
        .o_err_timeout(o_err_timeout), .o_overrun(o_overrun)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled on the inactive edge.
    always @(negedge clk) begin
        c_chk = c_chk + int'(o_err_chk);
        c_len = c_len + int'(o_err_len);
        c_tmo = c_tmo + int'(o_err_timeout);
        c_ovr = c_ovr + int'(o_overrun);
        if (int'(o_err_chk) + int'(o_err_len) + int'(o_err_timeout) + int'(o_overrun) > 1)
            c_multi = c_multi + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] b);
        rdy = 1'b1;
        din = b;
        @(posedge clk);
        #1;
        rdy = 1'b0;
        din = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Builds a well-formed frame into frm; pl keeps the payload for readback.
    task automatic build(input logic [7:0] addr, input int len);
        logic [7:0] x;
        pl.delete();
        for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
        x = addr ^ 8'(len);
        foreach (pl[i]) x = x ^ pl[i];
        frm = {8'hA5, addr, 8'(len)};
        foreach (pl[i]) frm.push_back(pl[i]);
        frm.push_back(x);
    endtask

    task automatic send_frm(input int gapmax);
        foreach (frm[i]) begin
            send(frm[i]);
            if (gapmax > 0 && i < frm.size() - 1) idle($urandom_range(0, gapmax));
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        n_cmp++;
        if ({o_frame_valid, o_frame_addr, o_frame_len, o_err_chk, o_err_len, o_err_timeout, o_overrun} !== 21'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {o_frame_valid, o_frame_addr, o_frame_len, o_err_chk, o_err_len, o_err_timeout, o_overrun});
        end
    endtask

    task automatic test_good_frame;
        logic [7:0] exp_d [3] = '{8'h01, 8'h02, 8'h03};
        frm = {8'hA5, 8'h12, 8'h03, 8'h01, 8'h02, 8'h03};
        foreach (frm[i]) send(frm[i]);
        n_cmp++;
        if (o_frame_valid !== 1'b0) begin n_bad++; $display("FAIL good_early_valid: got %b expected 0", o_frame_valid); end
        send(8'h11);
        n_cmp++;
        if ({o_frame_valid, o_frame_addr, o_frame_len} !== {1'b1, 8'h12, 8'h03}) begin
            n_bad++;
            $display("FAIL good_header: got %b/%h/%h expected 1/12/03", o_frame_valid, o_frame_addr, o_frame_len);
        end
        for (int i = 0; i < 3; i++) begin
            rd_idx = IDX_W'(i);
            @(negedge clk);
            n_cmp++;
            if (o_rd_data !== exp_d[i]) begin n_bad++; $display("FAIL good_read[%0d]: got %h expected %h", i, o_rd_data, exp_d[i]); end
        end
        @(posedge clk); #1;
        idle(3);
        n_cmp++;
        if (o_frame_valid !== 1'b1) begin n_bad++; $display("FAIL good_hold: got %b expected 1", o_frame_valid); end
        ack = 1'b1; idle(1); ack = 1'b0;
        n_cmp++;
        if (o_frame_valid !== 1'b0) begin n_bad++; $display("FAIL good_release: got %b expected 0", o_frame_valid); end
    endtask

    task automatic test_bad_chk;
        int c0 = c_chk;
        frm = {8'hA5, 8'h12, 8'h03, 8'h01, 8'h02, 8'h03, 8'h10};
        send_frm(0);
        idle(2);
        n_cmp++;
        if (c_chk - c0 !== 1 || o_frame_valid !== 1'b0) begin
            n_bad++; $display("FAIL bad_chk: got %0d pulses valid=%b expected 1 pulse valid=0", c_chk - c0, o_frame_valid);
        end
        build(8'h34, 4);
        send_frm(2);
        n_cmp++;
        if ({o_frame_valid, o_frame_addr, o_frame_len} !== {1'b1, 8'h34, 8'h04}) begin
            n_bad++; $display("FAIL after_bad_chk: got %b/%h/%h expected 1/34/04", o_frame_valid, o_frame_addr, o_frame_len);
        end
        ack = 1'b1; idle(1); ack = 1'b0;
    endtask

    task automatic test_len_bounds;
        int c0 = c_len;
        send(8'hA5); send(8'h07); send(8'h00);
        idle(2);
        n_cmp++;
        if (c_len - c0 !== 1) begin n_bad++; $display("FAIL len_zero: got %0d pulses expected 1", c_len - c0); end
        send(8'hA5); send(8'h07); send(8'h11);
        idle(2);
        n_cmp++;
        if (c_len - c0 !== 2 || o_frame_valid !== 1'b0) begin
            n_bad++; $display("FAIL len_17: got %0d pulses valid=%b expected 2 pulses valid=0", c_len - c0, o_frame_valid);
        end
        build(8'h07, MAX_LEN);
        send_frm(1);
        n_cmp++;
        if ({o_frame_valid, o_frame_addr, o_frame_len} !== {1'b1, 8'h07, 8'h10}) begin
            n_bad++; $display("FAIL len_max: got %b/%h/%h expected 1/07/10", o_frame_valid, o_frame_addr, o_frame_len);
        end
        for (int i = 0; i < MAX_LEN; i++) begin
            rd_idx = IDX_W'(i);
            @(negedge clk);
            n_cmp++;
            if (o_rd_data !== pl[i]) begin n_bad++; $display("FAIL len_max_read[%0d]: got %h expected %h", i, o_rd_data, pl[i]); end
        end
        @(posedge clk); #1;
        ack = 1'b1; idle(1); ack = 1'b0;
    endtask

    task automatic test_timeout;
        int c0 = c_tmo;
        int k = 0;
        send(8'hA5); send(8'h12); send(8'h03); send(8'h01);
        for (int i = 1; i <= 3 * TMO && k == 0; i++) begin
            @(posedge clk); #1;
            if (o_err_timeout === 1'b1) k = i;
        end
        n_cmp++;
        if (k !== TMO) begin n_bad++; $display("FAIL timeout_latency: got %0d cycles expected %0d", k, TMO); end
        send(8'h02); send(8'h03); send(8'h11);
        idle(1);
        n_cmp++;
        if (o_frame_valid !== 1'b0 || c_tmo - c0 !== 1) begin
            n_bad++; $display("FAIL timeout_to_hunt: got valid=%b pulses=%0d expected valid=0 pulses=1", o_frame_valid, c_tmo - c0);
        end
        c0 = c_tmo;
        send(8'hA5); send(8'h12); send(8'h03); send(8'h01);
        idle(TMO - 1);
        send(8'h02); send(8'h03); send(8'h11);
        n_cmp++;
        if (o_frame_valid !== 1'b1 || c_tmo - c0 !== 0) begin
            n_bad++; $display("FAIL timeout_byte_wins: got valid=%b pulses=%0d expected valid=1 pulses=0", o_frame_valid, c_tmo - c0);
        end
        ack = 1'b1; idle(1); ack = 1'b0;
    endtask

    task automatic test_overrun;
        int c0 = c_ovr;
        build(8'h5C, 5);
        send_frm(0);
        send(8'hA5); send(8'($urandom)); send(8'h3C);
        idle(1);
        n_cmp++;
        if (c_ovr - c0 !== 3 || {o_frame_valid, o_frame_addr, o_frame_len} !== {1'b1, 8'h5C, 8'h05}) begin
            n_bad++; $display("FAIL overrun_hold: got %0d pulses %b/%h/%h expected 3 pulses 1/5c/05",
                              c_ovr - c0, o_frame_valid, o_frame_addr, o_frame_len);
        end
        for (int i = 0; i < 5; i++) begin
            rd_idx = IDX_W'(i);
            @(negedge clk);
            n_cmp++;
            if (o_rd_data !== pl[i]) begin n_bad++; $display("FAIL overrun_read[%0d]: got %h expected %h", i, o_rd_data, pl[i]); end
        end
        @(posedge clk); #1;
        ack = 1'b1;
        send(8'hA5);
        ack = 1'b0;
        idle(1);
        n_cmp++;
        if (c_ovr - c0 !== 4 || o_frame_valid !== 1'b0) begin
            n_bad++; $display("FAIL ack_collision: got %0d pulses valid=%b expected 4 pulses valid=0", c_ovr - c0, o_frame_valid);
        end
        send(8'h12); send(8'h01); send(8'h7E); send(8'h6D);
        idle(1);
        n_cmp++;
        if (o_frame_valid !== 1'b0) begin n_bad++; $display("FAIL dropped_sync_seen: got %b expected 0", o_frame_valid); end
    endtask

    task automatic test_garbage;
        frm = {8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h12, 8'h01, 8'h7E};
        ack = 1'b1;
        foreach (frm[i]) send(frm[i]);
        ack = 1'b0;
        send(8'h6D);
        n_cmp++;
        if ({o_frame_valid, o_frame_addr, o_frame_len} !== {1'b1, 8'h12, 8'h01}) begin
            n_bad++; $display("FAIL garbage_header: got %b/%h/%h expected 1/12/01", o_frame_valid, o_frame_addr, o_frame_len);
        end
        rd_idx = '0;
        @(negedge clk);
        n_cmp++;
        if (o_rd_data !== 8'h7E) begin n_bad++; $display("FAIL garbage_read: got %h expected 7e", o_rd_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midframe;
        rst = 1'b1; idle(1); rst = 1'b0;
        n_cmp++;
        if ({o_frame_valid, o_frame_addr, o_frame_len} !== 17'd0) begin
            n_bad++; $display("FAIL reset_held: got %b/%h/%h expected 0/00/00", o_frame_valid, o_frame_addr, o_frame_len);
        end
        send(8'hA5); send(8'h12);
        rst = 1'b1; idle(1); rst = 1'b0;
        n_cmp++;
        if ({o_frame_valid, o_frame_addr, o_frame_len, o_err_chk, o_err_len, o_err_timeout, o_overrun} !== 21'd0) begin
            n_bad++; $display("FAIL reset_mid: got %h expected 0",
                              {o_frame_valid, o_frame_addr, o_frame_len, o_err_chk, o_err_len, o_err_timeout, o_overrun});
        end
        send(8'h03); send(8'h01); send(8'h02); send(8'h03); send(8'h11);
        idle(1);
        n_cmp++;
        if (o_frame_valid !== 1'b0) begin n_bad++; $display("FAIL reset_partial: got %b expected 0", o_frame_valid); end
        frm = {8'hA5, 8'h12, 8'h03, 8'h01, 8'h02, 8'h03, 8'h11};
        send_frm(0);
        n_cmp++;
        if ({o_frame_valid, o_frame_addr, o_frame_len} !== {1'b1, 8'h12, 8'h03}) begin
            n_bad++; $display("FAIL reset_next_frame: got %b/%h/%h expected 1/12/03", o_frame_valid, o_frame_addr, o_frame_len);
        end
        ack = 1'b1; idle(1); ack = 1'b0;
    endtask

    task automatic test_random;
        for (int it = 0; it < 40; it++) begin
            int kind = $urandom_range(0, 3);
            int e0 = c_chk + c_len + c_tmo + c_ovr;
            int l0 = c_len;
            int k0 = c_chk;
            logic [7:0] addr = 8'($urandom);
            int len = $urandom_range(1, MAX_LEN);
            if (kind == 1) begin
                for (int g = $urandom_range(1, 4); g > 0; g--) begin
                    logic [7:0] b = 8'($urandom);
                    if (b == 8'hA5) b = 8'h00;
                    send(b);
                end
            end
            if (kind == 3) begin
                logic [7:0] bl = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255));
                send(8'hA5); idle($urandom_range(0, 3)); send(addr); idle($urandom_range(0, 3)); send(bl);
                idle(2);
                n_cmp++;
                if (c_len - l0 !== 1 || o_frame_valid !== 1'b0) begin
                    n_bad++; $display("FAIL rnd_len[%0d]: len=%h got %0d pulses valid=%b expected 1 pulse valid=0", it, bl, c_len - l0, o_frame_valid);
                end
            end else if (kind == 2) begin
                build(addr, len);
                frm[frm.size() - 1] = frm[frm.size() - 1] ^ 8'($urandom_range(1, 255));
                send_frm(3);
                idle(2);
                n_cmp++;
                if (c_chk - k0 !== 1 || o_frame_valid !== 1'b0) begin
                    n_bad++; $display("FAIL rnd_chk[%0d]: got %0d pulses valid=%b expected 1 pulse valid=0", it, c_chk - k0, o_frame_valid);
                end
            end else begin
                build(addr, len);
                send_frm(3);
                n_cmp++;
                if ({o_frame_valid, o_frame_addr, o_frame_len} !== {1'b1, addr, 8'(len)}) begin
                    n_bad++; $display("FAIL rnd_header[%0d]: got %b/%h/%h expected 1/%h/%h", it, o_frame_valid, o_frame_addr, o_frame_len, addr, 8'(len));
                end
                for (int i = 0; i < len; i++) begin
                    rd_idx = IDX_W'(i);
                    @(negedge clk);
                    n_cmp++;
                    if (o_rd_data !== pl[i]) begin n_bad++; $display("FAIL rnd_read[%0d][%0d]: got %h expected %h", it, i, o_rd_data, pl[i]); end
                end
                @(posedge clk); #1;
                idle($urandom_range(0, 3));
                ack = 1'b1; idle(1); ack = 1'b0;
                idle(1);
                n_cmp++;
                if (o_frame_valid !== 1'b0 || (c_chk + c_len + c_tmo + c_ovr) - e0 !== 0) begin
                    n_bad++; $display("FAIL rnd_release[%0d]: got valid=%b errors=%0d expected valid=0 errors=0",
                                      it, o_frame_valid, (c_chk + c_len + c_tmo + c_ovr) - e0);
                end
            end
        end
    endtask

    task automatic test_exclusive;
        n_cmp++;
        if (c_multi !== 0) begin n_bad++; $display("FAIL pulse_exclusive: got %0d overlapping cycles expected 0", c_multi); end
    endtask

    initial begin
        test_reset;
        test_good_frame;
        test_bad_chk;
        test_len_bounds;
        test_timeout;
        test_overrun;
        test_garbage;
        test_reset_midframe;
        test_random;
        test_exclusive;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Sequences the byte stream from the UART receiver into validated command frames. It consumes the receiver's one-cycle data-ready pulse and data byte, and hunts for a sync byte. It then collects address, length, payload and checksum, and guards the frame with an inter-byte timeout. Each validated frame is held in a local buffer and presented to the downstream command decoder with a valid/ack handshake.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker.
MAX_LEN, 16, maximum payload bytes; buffer depth. Must be at least 2.
TIMEOUT_CLKS, 43400, maximum clocks between bytes inside a frame (about 10 byte times at 434 clocks per baud).

Ports:
i_clk  in  1  system clock.
i_rst  in  1  synchronous active-high reset.
i_data_ready  in  1  one-cycle pulse from the UART receiver: byte valid.
i_data_byte  in  8  received byte; sampled only when i_data_ready=1.
o_frame_valid  out  1  validated frame held; payload readable.
i_frame_ack  in  1  consumer releases the frame.
o_frame_addr  out  8  frame ADDR byte.
o_frame_len  out  8  frame payload length, 1..MAX_LEN.
i_rd_idx  in  $clog2(MAX_LEN)  payload read index.
o_rd_data  out  8  payload[i_rd_idx], combinational read.
o_err_chk  out  1  one-cycle pulse: checksum mismatch.
o_err_len  out  1  one-cycle pulse: LEN is 0 or greater than MAX_LEN.
o_err_timeout  out  1  one-cycle pulse: inter-byte timeout.
o_overrun  out  1  one-cycle pulse: byte dropped while in HOLD.

Behaviour:
- Reset: one clock and one synchronous active-high reset, named i_clk and i_rst. While i_rst=1 at a clock edge:
  - state goes to HUNT;
  - all outputs go to 0: o_frame_valid, o_frame_addr, o_frame_len, error and overrun pulses;
  - timeout counter, byte counter and running checksum are cleared.
  - Buffer contents are not reset. o_rd_data is don't-care while o_frame_valid=0.
- Frame format: SYNC, ADDR, LEN, LEN payload bytes, CHK.
  - CHK equals ADDR ^ LEN ^ every payload byte (8-bit XOR).
- States:
  - HUNT: on a byte equal to SYNC_BYTE, go to ADDR. Any other byte is ignored silently.
  - ADDR: on a byte, latch it to the address register, set checksum = byte, go to LEN.
  - LEN: on a byte:
    - if LEN = 0 or LEN > MAX_LEN, pulse o_err_len and go to HUNT;
    - otherwise latch LEN, XOR it into the checksum, clear the byte counter and go to PAYLOAD.
  - PAYLOAD: on a byte, write buffer[counter], XOR into the checksum and increment the counter. When the counter reaches LEN-1 on that byte, go to CHK.
  - CHK: on a byte:
    - if it equals the checksum, go to HOLD;
    - otherwise pulse o_err_chk and go to HUNT.
  - HOLD:
    - o_frame_valid=1; o_frame_addr and o_frame_len are stable.
    - On i_frame_ack=1, clear o_frame_valid on the next edge and go to HUNT.
- Latency: o_frame_valid rises at the edge after the CHK byte's i_data_ready cycle. Error pulses also appear the cycle after the offending byte.
- Timeout:
  - The counter runs only in ADDR, LEN, PAYLOAD and CHK.
  - It is cleared on every accepted byte and on entry from HUNT.
  - When it reaches TIMEOUT_CLKS-1 with no byte, pulse o_err_timeout and go to HUNT.
  - If a byte arrives in the expiry cycle, the byte wins: it is processed and there is no timeout.
  - Counter width is $clog2(TIMEOUT_CLKS) bits; it never wraps.
- Overrun and ack collisions:
  - Any byte arriving in HOLD is dropped and o_overrun pulses; the buffer and header are unchanged.
  - Ack and a byte in the same cycle: the byte is dropped with o_overrun, then go to HUNT. A SYNC byte dropped this way is not seen, so no hunt is triggered by it.
  - i_frame_ack outside HOLD is ignored.
- Buffer reads: o_rd_data is valid while o_frame_valid=1 and i_rd_idx < o_frame_len. Reads at i_rd_idx >= o_frame_len return undefined data.
- Error pulses are mutually exclusive in any cycle and last exactly one cycle.
- Reset mid-frame: the partial frame is discarded. The next frame is accepted only after a new SYNC.

Test Plan:
- Good frame A5 12 03 01 02 03 11 -> o_frame_valid=1 one cycle after the last byte; addr=0x12, len=3; rd_idx 0..2 gives 01 02 03. Holds until ack, then valid=0 on the next cycle.
- Bad checksum: A5 12 03 01 02 03 10 -> o_err_chk pulses once; o_frame_valid stays 0; a following good frame is accepted.
- Length bounds:
  - A5 07 00 -> o_err_len pulses once.
  - A5 07 11 (17 > MAX_LEN) -> o_err_len pulses once.
  - A5 07 10 with a correct 16-byte payload -> valid, len=16.
- Timeout:
  - A5 12 03 01, then silence -> o_err_timeout pulses exactly TIMEOUT_CLKS cycles after the 01 byte; state returns to HUNT.
  - A byte landing in the expiry cycle -> no pulse; the frame continues.
- Overrun: a good frame is held with no ack; send 3 bytes -> three o_overrun pulses, buffer readback unchanged. Ack in the same cycle as a byte -> overrun pulse plus release.
- Garbage and reset:
  - 00 FF 5A A5 12 01 7E 6D -> non-sync bytes are ignored and the frame is valid (addr=12, len=1, data=7E).
  - Assert i_rst after A5 12 -> all outputs 0; a subsequent full good frame is accepted.
